match_sequencer: RTL
====================

Name: match_sequencer

Overview:
- Top-level game-flow controller for the VGA ping-pong core.
- Sequences the ball/direction datapath through idle, serve, play, goal-hold, pause and game-over phases.
- Owns the reset and run enables of the ball logic, and converts the ball logic's goal flags into per-player scores and a winner.
- Sits between the button debouncers, the frame-tick generator, the ball/direction logic and the score display.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..15.
- SERVE_DELAY, 60, frame ticks spent in SERVE before the ball is released; 0 is treated as 1; legal range 0..255.
- GOAL_HOLD, 90, frame ticks the ball stays frozen after a point; 0 is treated as 1; legal range 0..255.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous reset, active-low.
- frame_tick  in  1  one-cycle pulse, once per frame.
- start_btn  in  1  debounced level; acted on at its rising edge.
- pause_btn  in  1  debounced level; acted on at its rising edge.
- goal_p1  in  1  level from ball logic; high means the ball passed P1's paddle, which is a point for P2.
- goal_p2  in  1  level from ball logic; high means the ball passed P2's paddle, which is a point for P1.
- ball_rst  out  1  active-high reset to the ball position and direction logic.
- ball_run  out  1  movement enable for the ball logic.
- score_p1  out  4  P1 score.
- score_p2  out  4  P2 score.
- winner  out  2  00 none, 01 P1, 10 P2.
- state  out  3  current state code, for display/debug.

Behaviour:
- All flops update on posedge clk.
- When rst is 0 at a clock edge:
  - state = IDLE.
  - score_p1 = score_p2 = 0, winner = 00, frame counter = 0.
  - All edge-detect history registers = 0.
- Edge detect: each of start_btn, pause_btn, goal_p1 and goal_p2 has a registered previous value. An edge means current value is 1 and previous value is 0.
- States and codes: IDLE=0, SERVE=1, PLAY=2, GOAL=3, PAUSE=4, OVER=5.
- ball_rst and ball_run are a pure decode of the state register:
  - IDLE, SERVE, OVER: ball_rst=1, ball_run=0.
  - PLAY: ball_rst=0, ball_run=1.
  - GOAL, PAUSE: ball_rst=0, ball_run=0 (ball frozen).
- Latency: every transition takes effect on the clock edge following the triggering input. Outputs change in that same cycle.
- Frame counter (8-bit):
  - Cleared on entry to SERVE and GOAL.
  - Increments only on frame_tick while in SERVE or GOAL.
  - Holds in every other state.
  - In SERVE, exits to PLAY on a frame_tick with counter == max(SERVE_DELAY,1)-1.
  - In GOAL, exits on a frame_tick with counter == max(GOAL_HOLD,1)-1.
  - The counter never wraps for legal parameter values.
- IDLE: a start edge clears both scores and winner, then goes to SERVE.
- PLAY:
  - goal_p1 edge alone: score_p2+1; go to OVER with winner=10 if the new score == WIN_SCORE, else go to GOAL.
  - goal_p2 edge alone: score_p1+1; same rule with winner=01.
  - Both goal edges in the same cycle: no score change; go to GOAL (let).
  - A pause edge in the same cycle as a goal edge is ignored; the goal wins.
  - pause edge with no goal edge: go to PAUSE.
- GOAL: timer expiry goes to SERVE.
- PAUSE:
  - Frame counter and scores hold.
  - Goal edges are ignored.
  - A pause edge returns to PLAY.
- OVER: scores and winner hold; a start edge goes to IDLE with scores and winner unchanged until the next start.
- Goal, start and pause edges are ignored in every state not listed above.
- History registers update every cycle in all states. A level already high on entering PLAY therefore does not score.
- Scores saturate at WIN_SCORE and never wrap.
- Reset asserted in any state, including mid-count, takes priority over every other event the same cycle.

Test Plan:
All scenarios use WIN_SCORE=3, SERVE_DELAY=2, GOAL_HOLD=3.
1. Hold rst=0 for 2 cycles, then release -> state=0, ball_rst=1, ball_run=0, scores 0/0, winner=00.
2. Start pulse in IDLE, then 2 frame_ticks -> state=1 for exactly 2 ticks, then state=2 with ball_rst=0 and ball_run=1 one cycle after the 2nd tick.
3. Raise goal_p2 and hold it 20 cycles in PLAY -> score_p1=1 exactly once, state=3. After 3 ticks state=1; after 2 more ticks state=2. The still-high goal_p2 does not score again.
4. Raise goal_p1 and goal_p2 in the same cycle in PLAY -> scores unchanged, state=3.
5. Pause edge in PLAY -> state=4, ball_run=0. Frame ticks and goal pulses cause no change. A second pause edge -> state=2.
6. Three P2 points -> after the 3rd, score_p2=3, winner=10, state=5, ball_rst=1. Start edge -> state=0; next start edge -> scores 0/0, winner=00, state=1. Asserting rst while in GOAL mid-count -> state=0 next cycle.

Source files
------------

// File: rtl/match_sequencer.sv
// Game-flow controller for the ping-pong core: sequences serve/play/goal/pause/over,
// drives the ball logic enables and keeps per-player scores and the winner.
module match_sequencer #(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 60,
  parameter int GOAL_HOLD   = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       ball_rst,
  output logic       ball_run,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_GOAL  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_OVER  = 3'd5;

  localparam logic [3:0] WIN4       = 4'(WIN_SCORE);
  // A zero delay behaves like one tick so the timer always has a terminal value.
  localparam logic [7:0] SERVE_LAST = (SERVE_DELAY <= 1) ? 8'd0 : 8'(SERVE_DELAY - 1);
  localparam logic [7:0] GOAL_LAST  = (GOAL_HOLD <= 1) ? 8'd0 : 8'(GOAL_HOLD - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_p1_q, score_p1_d;
  logic [3:0] score_p2_q, score_p2_d;
  logic [1:0] winner_q, winner_d;
  logic       start_prev_q, pause_prev_q, gp1_prev_q, gp2_prev_q;

  logic start_e, pause_e, gp1_e, gp2_e;
  logic [3:0] p1_inc, p2_inc;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= WIN4) ? WIN4 : s + 4'd1;
  endfunction

  assign start_e = start_btn & ~start_prev_q;
  assign pause_e = pause_btn & ~pause_prev_q;
  assign gp1_e   = goal_p1 & ~gp1_prev_q;
  assign gp2_e   = goal_p2 & ~gp2_prev_q;

  assign p1_inc = sat_inc(score_p1_q);
  assign p2_inc = sat_inc(score_p2_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    winner_d   = winner_q;
    case (state_q)
      S_IDLE: begin
        if (start_e) begin
          score_p1_d = 4'd0;
          score_p2_d = 4'd0;
          winner_d   = 2'b00;
          cnt_d      = 8'd0;
          state_d    = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) state_d = S_PLAY;
          else                     cnt_d   = cnt_q + 8'd1;
        end
      end
      S_PLAY: begin
        // Goals take precedence over a coincident pause; a double goal is a let.
        if (gp1_e && gp2_e) begin
          cnt_d   = 8'd0;
          state_d = S_GOAL;
        end else if (gp1_e) begin
          score_p2_d = p2_inc;
          if (p2_inc == WIN4) begin
            winner_d = 2'b10;
            state_d  = S_OVER;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_GOAL;
          end
        end else if (gp2_e) begin
          score_p1_d = p1_inc;
          if (p1_inc == WIN4) begin
            winner_d = 2'b01;
            state_d  = S_OVER;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_GOAL;
          end
        end else if (pause_e) begin
          state_d = S_PAUSE;
        end
      end
      S_GOAL: begin
        if (frame_tick) begin
          if (cnt_q == GOAL_LAST) begin
            cnt_d   = 8'd0;
            state_d = S_SERVE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_PAUSE: begin
        if (pause_e) state_d = S_PLAY;
      end
      S_OVER: begin
        if (start_e) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      score_p1_q   <= 4'd0;
      score_p2_q   <= 4'd0;
      winner_q     <= 2'b00;
      start_prev_q <= 1'b0;
      pause_prev_q <= 1'b0;
      gp1_prev_q   <= 1'b0;
      gp2_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score_p1_q   <= score_p1_d;
      score_p2_q   <= score_p2_d;
      winner_q     <= winner_d;
      start_prev_q <= start_btn;
      pause_prev_q <= pause_btn;
      gp1_prev_q   <= goal_p1;
      gp2_prev_q   <= goal_p2;
    end
  end

  assign ball_rst = (state_q == S_IDLE) || (state_q == S_SERVE) || (state_q == S_OVER);
  assign ball_run = (state_q == S_PLAY);
  assign score_p1 = score_p1_q;
  assign score_p2 = score_p2_q;
  assign winner   = winner_q;
  assign state    = state_q;

endmodule
